mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one external memory port between the IF-stage instruction fetch and the MEM-stage data access of the pipeline.
- Arbitrates between the two, holds the selected request stable on the port until the memory acknowledges, and returns read data with a one-cycle done pulse.
- Generates stall signals that the hazard unit uses to freeze the stages involved.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 15, cycles mem_req may stay high without mem_ready before a bus error (1..255).

Ports:
- clk  in  1  clock
- reset_x  in  1  asynchronous active-low reset
- i_ireq  in  1  fetch request, held until i_idone
- i_iaddr  in  AW  fetch address
- i_dreq  in  1  data request, held until i_ddone (controller memReq)
- i_dwrite  in  1  data write enable (controller memWrite)
- i_dsize  in  2  0=byte, 1=half, 2=word (controller memSize)
- i_daddr  in  AW  data address
- i_dwdata  in  DW  store data
- i_mem_ready  in  1  memory acknowledge for the current access
- i_mem_rdata  in  DW  memory read data, valid with i_mem_ready
- o_mem_req  out  1  port request
- o_mem_write  out  1  port write enable
- o_mem_size  out  2  port size (fetch always 2)
- o_mem_addr  out  AW  port address
- o_mem_wdata  out  DW  port write data
- o_idone  out  1  one-cycle fetch completion pulse
- o_irdata  out  DW  fetched instruction, held until the next fetch completes
- o_ddone  out  1  one-cycle data completion pulse
- o_drdata  out  DW  load data, held until the next data access completes
- o_stall_if  out  1  i_ireq & ~o_idone (combinational)
- o_stall_mem  out  1  i_dreq & ~o_ddone (combinational)
- o_bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: all registered outputs 0; state IDLE; wait counter 0; last_grant = INST.
- FSM states:
  - IDLE: arbitrate.
  - DATA: data access on the port.
  - INST: fetch on the port.
- Grant in IDLE:
  - Masking: a request whose done pulse is high in the current cycle is ignored, so a held request cannot retrigger.
  - Only data pending -> DATA. Only fetch pending -> INST.
  - Both pending -> DATA, unless last_grant = DATA, in which case INST. This alternates under contention, and no requester waits more than one access.
- On the grant edge: latch addr/size/wdata/write into port registers and assert o_mem_req. A fetch drives o_mem_write=0 and o_mem_size=2.
- Port registers stay constant while o_mem_req=1.
- In DATA/INST, on a cycle with i_mem_ready=1:
  - At the next edge: o_mem_req=0, read data captured into o_drdata/o_irdata (writes leave o_drdata unchanged), matching done pulse asserted for one cycle, last_grant updated, return to IDLE.
- Minimum latency: request seen in cycle 0 -> o_mem_req in cycle 1 -> i_mem_ready in cycle 1 -> done pulse in cycle 2. Next grant is possible in cycle 2 and the port is busy from cycle 3.
- Wait counter:
  - Clears on grant and increments each cycle o_mem_req=1 without i_mem_ready.
  - When it reaches MAX_WAIT: pulse o_bus_err together with the done pulse, capture read data as 0, return to IDLE.
- i_mem_ready in IDLE is ignored.
- Requester behaviour: a requester that drops its request before done does not abort the access in flight. The result is discarded and the done pulse is still issued.
- Reset mid-access: o_mem_req drops immediately (async) and no done pulse is issued.

Decomposition:
- Shared package: state encoding (IDLE=0, DATA=1, INST=2), size constants (BYTE/HALF/WORD), WAIT_W = clog2(MAX_WAIT+1).
- One sub-module, arb_wait_counter (clear/enable/terminal-count flag). Everything else stays inline.

Test Plan:
- Single fetch: i_ireq, iaddr=0x100, memory ready 1 cycle after o_mem_req, rdata=0x00500093 -> o_mem_addr=0x100, size=2, write=0; o_idone in cycle 2; o_irdata=0x00500093; o_stall_if high in cycles 0-1.
- Simultaneous requests: ireq at 0x200, dreq load at 0x1000 -> data served first, then fetch. Repeat with data re-requesting -> fetch is granted before the second data access.
- Store: dwrite=1, size=0, addr=0x1003, wdata=0xAB, memory waits 3 cycles -> port fields stable for 4 cycles; o_ddone once; o_drdata unchanged.
- Timeout: MAX_WAIT=4, memory never ready -> o_bus_err and o_idone pulse 4 cycles after o_mem_req rises; o_irdata=0; FSM returns to IDLE.
- Reset asserted mid-DATA -> o_mem_req=0 asynchronously, no done pulse. After release, a pending ireq is granted normally.
- Held request after done: ireq stays high for the done cycle -> no second grant in that cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } arbState_t;

    // Which requester was served by the most recent completed access
    typedef enum logic {
        GRANT_DATA = 1'b0,
        GRANT_INST = 1'b1
    } grant_t;

    // Access size codes on the memory port
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int MAX_WAIT_DEFAULT = 15;

    // Width of a counter that must be able to hold the value maxWait
    function automatic int waitWidth(input int maxWait);
        return $clog2(maxWait + 1);
    endfunction

    localparam int WAIT_W = waitWidth(MAX_WAIT_DEFAULT);

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Counts cycles an access waits for the memory acknowledge and flags the
// cycle on which the next un-acknowledged edge would reach the timeout value.
module arb_wait_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15
) (
    input  logic clk,
    input  logic reset_x,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_COUNT - 1);

    logic [WIDTH-1:0] count;

    // Clear while idle, count every waiting cycle of an access
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The edge that moves the count to MAX_COUNT is the timeout edge
    assign terminal = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, holding
// the granted request until acknowledge or timeout, with one-cycle done pulses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset_x,
    input  logic          i_ireq,
    input  logic [AW-1:0] i_iaddr,
    input  logic          i_dreq,
    input  logic          i_dwrite,
    input  logic [1:0]    i_dsize,
    input  logic [AW-1:0] i_daddr,
    input  logic [DW-1:0] i_dwdata,
    input  logic          i_mem_ready,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_mem_req,
    output logic          o_mem_write,
    output logic [1:0]    o_mem_size,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_idone,
    output logic [DW-1:0] o_irdata,
    output logic          o_ddone,
    output logic [DW-1:0] o_drdata,
    output logic          o_stall_if,
    output logic          o_stall_mem,
    output logic          o_bus_err
);
    localparam int WAIT_BITS = waitWidth(MAX_WAIT);

    arbState_t state;
    grant_t    lastGrant;
    logic      dPend;
    logic      iPend;
    logic      grantData;
    logic      grantInst;
    logic      waitClr;
    logic      waitEn;
    logic      waitTc;

    // A request whose done pulse is visible this cycle is already served
    assign dPend = i_dreq & ~o_ddone;
    assign iPend = i_ireq & ~o_idone;

    assign o_stall_if  = i_ireq & ~o_idone;
    assign o_stall_mem = i_dreq & ~o_ddone;

    // Arbitration: data wins contention unless it was served last
    always_comb begin
        grantData = 1'b0;
        grantInst = 1'b0;
        if (state == IDLE) begin
            grantData = dPend & (~iPend | (lastGrant == GRANT_INST));
            grantInst = iPend & (~dPend | (lastGrant == GRANT_DATA));
        end
    end

    assign waitClr = (state == IDLE);
    assign waitEn  = o_mem_req & ~i_mem_ready;

    arb_wait_counter #(
        .WIDTH     (WAIT_BITS),
        .MAX_COUNT (MAX_WAIT)
    ) uWaitCounter (
        .clk      (clk),
        .reset_x  (reset_x),
        .clear    (waitClr),
        .enable   (waitEn),
        .terminal (waitTc)
    );

    // Port FSM with registered port fields, read data and completion pulses
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state       <= IDLE;
            lastGrant   <= GRANT_INST;
            o_mem_req   <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_size  <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_idone     <= 1'b0;
            o_irdata    <= '0;
            o_ddone     <= 1'b0;
            o_drdata    <= '0;
            o_bus_err   <= 1'b0;
        end else begin
            o_idone   <= 1'b0;
            o_ddone   <= 1'b0;
            o_bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantData) begin
                        state       <= DATA;
                        o_mem_req   <= 1'b1;
                        o_mem_write <= i_dwrite;
                        o_mem_size  <= i_dsize;
                        o_mem_addr  <= i_daddr;
                        o_mem_wdata <= i_dwdata;
                    end else if (grantInst) begin
                        state       <= INST;
                        o_mem_req   <= 1'b1;
                        o_mem_write <= 1'b0;
                        o_mem_size  <= SIZE_WORD;
                        o_mem_addr  <= i_iaddr;
                        o_mem_wdata <= '0;
                    end
                end
                DATA: begin
                    if (i_mem_ready || waitTc) begin
                        state     <= IDLE;
                        o_mem_req <= 1'b0;
                        o_ddone   <= 1'b1;
                        o_bus_err <= ~i_mem_ready;
                        lastGrant <= GRANT_DATA;
                        if (!o_mem_write) begin
                            o_drdata <= i_mem_ready ? i_mem_rdata : '0;
                        end
                    end
                end
                INST: begin
                    if (i_mem_ready || waitTc) begin
                        state     <= IDLE;
                        o_mem_req <= 1'b0;
                        o_idone   <= 1'b1;
                        o_bus_err <= ~i_mem_ready;
                        lastGrant <= GRANT_INST;
                        o_irdata  <= i_mem_ready ? i_mem_rdata : '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (MAX_WAIT = 4).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        i_ireq;
    logic [31:0] i_iaddr;
    logic        i_dreq;
    logic        i_dwrite;
    logic [1:0]  i_dsize;
    logic [31:0] i_daddr;
    logic [31:0] i_dwdata;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;
    logic        o_mem_req;
    logic        o_mem_write;
    logic [1:0]  o_mem_size;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_idone;
    logic [31:0] o_irdata;
    logic        o_ddone;
    logic [31:0] o_drdata;
    logic        o_stall_if;
    logic        o_stall_mem;
    logic        o_bus_err;

    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW       (32),
        .DW       (32),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .reset_x     (reset_x),
        .i_ireq      (i_ireq),
        .i_iaddr     (i_iaddr),
        .i_dreq      (i_dreq),
        .i_dwrite    (i_dwrite),
        .i_dsize     (i_dsize),
        .i_daddr     (i_daddr),
        .i_dwdata    (i_dwdata),
        .i_mem_ready (i_mem_ready),
        .i_mem_rdata (i_mem_rdata),
        .o_mem_req   (o_mem_req),
        .o_mem_write (o_mem_write),
        .o_mem_size  (o_mem_size),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_idone     (o_idone),
        .o_irdata    (o_irdata),
        .o_ddone     (o_ddone),
        .o_drdata    (o_drdata),
        .o_stall_if  (o_stall_if),
        .o_stall_mem (o_stall_mem),
        .o_bus_err   (o_bus_err)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic        rdy;
        logic [31:0] rdata;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eIdone;
        logic [31:0] eIrdata;
        logic        eDdone;
        logic [31:0] eDrdata;
        logic        eStallIf;
        logic        eStallMem;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passCnt++;
        end
    endtask

    // Advance to the next cycle; inputs are driven 2 time units after the edge
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // ireq iaddr dreq daddr rdy rdata | req addr idone irdata ddone drdata stallIf stallMem
        vecs[0]  = '{1, 32'h100, 0, 32'h0,    0, 32'h0,        0, 32'h0,    0, 32'h0,        0, 32'h0,        1, 0};
        vecs[1]  = '{1, 32'h100, 0, 32'h0,    1, 32'h00500093, 1, 32'h100,  0, 32'h0,        0, 32'h0,        1, 0};
        vecs[2]  = '{1, 32'h100, 0, 32'h0,    0, 32'h0,        0, 32'h0,    1, 32'h00500093, 0, 32'h0,        0, 0};
        vecs[3]  = '{0, 32'h0,   0, 32'h0,    0, 32'h0,        0, 32'h0,    0, 32'h00500093, 0, 32'h0,        0, 0};
        vecs[4]  = '{1, 32'h200, 1, 32'h1000, 0, 32'h0,        0, 32'h0,    0, 32'h00500093, 0, 32'h0,        1, 1};
        vecs[5]  = '{1, 32'h200, 1, 32'h1000, 1, 32'hDEADBEEF, 1, 32'h1000, 0, 32'h00500093, 0, 32'h0,        1, 1};
        vecs[6]  = '{1, 32'h200, 1, 32'h1000, 0, 32'h0,        0, 32'h0,    0, 32'h00500093, 1, 32'hDEADBEEF, 1, 0};
        vecs[7]  = '{1, 32'h200, 0, 32'h0,    1, 32'h11111111, 1, 32'h200,  0, 32'h00500093, 0, 32'hDEADBEEF, 1, 0};
        vecs[8]  = '{1, 32'h200, 0, 32'h0,    0, 32'h0,        0, 32'h0,    1, 32'h11111111, 0, 32'hDEADBEEF, 0, 0};
        vecs[9]  = '{0, 32'h0,   0, 32'h0,    0, 32'h0,        0, 32'h0,    0, 32'h11111111, 0, 32'hDEADBEEF, 0, 0};
        vecs[10] = '{1, 32'h300, 1, 32'h2000, 0, 32'h0,        0, 32'h0,    0, 32'h11111111, 0, 32'hDEADBEEF, 1, 1};
        vecs[11] = '{1, 32'h300, 1, 32'h2000, 1, 32'h22222222, 1, 32'h2000, 0, 32'h11111111, 0, 32'hDEADBEEF, 1, 1};
        vecs[12] = '{1, 32'h300, 1, 32'h2000, 0, 32'h0,        0, 32'h0,    0, 32'h11111111, 1, 32'h22222222, 1, 0};
        vecs[13] = '{1, 32'h300, 1, 32'h2004, 0, 32'h0,        1, 32'h300,  0, 32'h11111111, 0, 32'h22222222, 1, 1};
        vecs[14] = '{1, 32'h300, 1, 32'h2004, 1, 32'h33333333, 1, 32'h300,  0, 32'h11111111, 0, 32'h22222222, 1, 1};
        vecs[15] = '{1, 32'h300, 1, 32'h2004, 0, 32'h0,        0, 32'h0,    1, 32'h33333333, 0, 32'h22222222, 0, 1};
        vecs[16] = '{0, 32'h0,   1, 32'h2004, 1, 32'h44444444, 1, 32'h2004, 0, 32'h33333333, 0, 32'h22222222, 0, 1};
        vecs[17] = '{0, 32'h0,   1, 32'h2004, 0, 32'h0,        0, 32'h0,    0, 32'h33333333, 1, 32'h44444444, 0, 0};
        vecs[18] = '{0, 32'h0,   0, 32'h0,    0, 32'h0,        0, 32'h0,    0, 32'h33333333, 0, 32'h44444444, 0, 0};

        reset_x     = 1'b0;
        i_ireq      = 1'b0;
        i_iaddr     = '0;
        i_dreq      = 1'b0;
        i_dwrite    = 1'b0;
        i_dsize     = 2'd2;
        i_daddr     = '0;
        i_dwdata    = '0;
        i_mem_ready = 1'b0;
        i_mem_rdata = '0;

        nextCycle();
        nextCycle();
        #1;
        check("reset_req", 32'(o_mem_req), 32'h0);
        check("reset_idone", 32'(o_idone), 32'h0);
        check("reset_ddone", 32'(o_ddone), 32'h0);
        check("reset_irdata", o_irdata, 32'h0);
        check("reset_drdata", o_drdata, 32'h0);
        check("reset_buserr", 32'(o_bus_err), 32'h0);
        reset_x = 1'b1;

        // Fetch, contention and alternation table
        for (int i = 0; i < 19; i++) begin
            nextCycle();
            i_ireq      = vecs[i].ireq;
            i_iaddr     = vecs[i].iaddr;
            i_dreq      = vecs[i].dreq;
            i_dwrite    = 1'b0;
            i_dsize     = 2'd2;
            i_daddr     = vecs[i].daddr;
            i_dwdata    = '0;
            i_mem_ready = vecs[i].rdy;
            i_mem_rdata = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_req", i), 32'(o_mem_req), 32'(vecs[i].eReq));
            if (vecs[i].eReq) begin
                check($sformatf("v%0d_addr", i), o_mem_addr, vecs[i].eAddr);
                check($sformatf("v%0d_size", i), 32'(o_mem_size), 32'h2);
                check($sformatf("v%0d_write", i), 32'(o_mem_write), 32'h0);
            end
            check($sformatf("v%0d_idone", i), 32'(o_idone), 32'(vecs[i].eIdone));
            check($sformatf("v%0d_irdata", i), o_irdata, vecs[i].eIrdata);
            check($sformatf("v%0d_ddone", i), 32'(o_ddone), 32'(vecs[i].eDdone));
            check($sformatf("v%0d_drdata", i), o_drdata, vecs[i].eDrdata);
            check($sformatf("v%0d_stallif", i), 32'(o_stall_if), 32'(vecs[i].eStallIf));
            check($sformatf("v%0d_stallmem", i), 32'(o_stall_mem), 32'(vecs[i].eStallMem));
            check($sformatf("v%0d_buserr", i), 32'(o_bus_err), 32'h0);
        end

        // Byte store with three wait cycles
        nextCycle();
        i_dreq = 1'b1; i_dwrite = 1'b1; i_dsize = 2'd0;
        i_daddr = 32'h1003; i_dwdata = 32'hAB; i_mem_ready = 1'b0;
        #1;
        check("st_req0", 32'(o_mem_req), 32'h0);
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            i_mem_ready = (c == 4);
            i_mem_rdata = 32'hFFFFFFFF;
            #1;
            check($sformatf("st%0d_req", c), 32'(o_mem_req), 32'h1);
            check($sformatf("st%0d_write", c), 32'(o_mem_write), 32'h1);
            check($sformatf("st%0d_size", c), 32'(o_mem_size), 32'h0);
            check($sformatf("st%0d_addr", c), o_mem_addr, 32'h1003);
            check($sformatf("st%0d_wdata", c), o_mem_wdata, 32'hAB);
            check($sformatf("st%0d_ddone", c), 32'(o_ddone), 32'h0);
        end
        nextCycle();
        i_mem_ready = 1'b0;
        #1;
        check("st_ddone", 32'(o_ddone), 32'h1);
        check("st_drdata", o_drdata, 32'h44444444);
        check("st_req_end", 32'(o_mem_req), 32'h0);
        check("st_buserr", 32'(o_bus_err), 32'h0);
        nextCycle();
        i_dreq = 1'b0; i_dwrite = 1'b0; i_dsize = 2'd2;
        #1;
        check("st_ddone_once", 32'(o_ddone), 32'h0);
        check("st_req_idle", 32'(o_mem_req), 32'h0);

        // Fetch timeout: memory never acknowledges
        nextCycle();
        i_ireq = 1'b1; i_iaddr = 32'h400;
        #1;
        check("to_req0", 32'(o_mem_req), 32'h0);
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            #1;
            check($sformatf("to%0d_req", c), 32'(o_mem_req), 32'h1);
            check($sformatf("to%0d_addr", c), o_mem_addr, 32'h400);
            check($sformatf("to%0d_buserr", c), 32'(o_bus_err), 32'h0);
            check($sformatf("to%0d_idone", c), 32'(o_idone), 32'h0);
        end
        nextCycle();
        #1;
        check("to_buserr", 32'(o_bus_err), 32'h1);
        check("to_idone", 32'(o_idone), 32'h1);
        check("to_irdata", o_irdata, 32'h0);
        check("to_req_drop", 32'(o_mem_req), 32'h0);
        nextCycle();
        i_ireq = 1'b0;
        #1;
        check("to_buserr_once", 32'(o_bus_err), 32'h0);
        check("to_idle", 32'(o_mem_req), 32'h0);

        // Reset in the middle of a data access
        nextCycle();
        i_dreq = 1'b1; i_daddr = 32'h5000;
        nextCycle();
        #1;
        check("rs_req_before", 32'(o_mem_req), 32'h1);
        reset_x = 1'b0;
        #1;
        check("rs_req_async", 32'(o_mem_req), 32'h0);
        check("rs_ddone", 32'(o_ddone), 32'h0);
        i_dreq = 1'b0; i_ireq = 1'b1; i_iaddr = 32'h600;
        nextCycle();
        reset_x = 1'b1;
        #1;
        check("rs_release_req", 32'(o_mem_req), 32'h0);
        check("rs_release_ddone", 32'(o_ddone), 32'h0);
        nextCycle();
        i_mem_ready = 1'b1; i_mem_rdata = 32'h55555555;
        #1;
        check("rs_fetch_req", 32'(o_mem_req), 32'h1);
        check("rs_fetch_addr", o_mem_addr, 32'h600);
        check("rs_fetch_ddone", 32'(o_ddone), 32'h0);
        nextCycle();
        i_mem_ready = 1'b0; i_ireq = 1'b0;
        #1;
        check("rs_fetch_idone", 32'(o_idone), 32'h1);
        check("rs_fetch_irdata", o_irdata, 32'h55555555);
        check("rs_fetch_ddone2", 32'(o_ddone), 32'h0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
